// File: rtl/maze_pkg.sv
// Shared definitions for the maze player-position engine: direction codes and FSM states.
package maze_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2,
        WIN   = 2'd3
    } state_t;

endpackage

// File: rtl/maze_move_check.sv
// Combinational move evaluator: decodes the direction, checks grid edges first and
// only then looks up the wall bitmap, so an out-of-range cell is never indexed.
module maze_move_check
    import maze_pkg::*;
#(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15,
    localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1,
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1,
    localparam int IW = (MAP_W * MAP_H > 1) ? $clog2(MAP_W * MAP_H) : 1
) (
    input  logic [XW-1:0]          px,
    input  logic [YW-1:0]          py,
    input  logic [3:0]             dir,
    input  logic [MAP_W*MAP_H-1:0] map_bits,
    output logic                   valid,
    output logic                   blocked,
    output logic [XW-1:0]          nx,
    output logic [YW-1:0]          ny
);

    logic          edge_hit;
    logic          wall;
    logic [IW-1:0] idx;

    always_comb begin
        valid    = 1'b1;
        edge_hit = 1'b0;
        nx       = px;
        ny       = py;
        case (dir)
            DIR_LEFT: begin
                if (px == '0) edge_hit = 1'b1;
                else          nx = px - 1'b1;
            end
            DIR_RIGHT: begin
                if (px == XW'(MAP_W - 1)) edge_hit = 1'b1;
                else                      nx = px + 1'b1;
            end
            DIR_UP: begin
                if (py == '0) edge_hit = 1'b1;
                else          ny = py - 1'b1;
            end
            DIR_DOWN: begin
                if (py == YW'(MAP_H - 1)) edge_hit = 1'b1;
                else                      ny = py + 1'b1;
            end
            default: valid = 1'b0;
        endcase

        idx  = '0;
        wall = 1'b0;
        if (valid && !edge_hit) begin
            idx  = IW'(int'(ny) * MAP_W + int'(nx));
            wall = map_bits[idx];
        end
        blocked = valid && (edge_hit || wall);
    end

endmodule

// File: rtl/maze_walker.sv
// Player-position engine: steps the player one cell per move tick, refuses moves into
// walls or off-grid, counts successful steps and latches arrival at the exit cell.
module maze_walker
    import maze_pkg::*;
#(
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int EXIT_X    = 19,
    parameter int EXIT_Y    = 7,
    parameter int STEP_W    = 16,
    parameter int EDGE_MODE = 0,
    localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1,
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tick,
    input  logic [3:0]             dir,
    input  logic                   restart,
    input  logic [MAP_W*MAP_H-1:0] map_bits,
    output logic [XW-1:0]          px,
    output logic [YW-1:0]          py,
    output logic                   win,
    output logic                   bump,
    output logic [STEP_W-1:0]      steps
);

    state_t              state, state_nx;
    logic [XW-1:0]       px_nx;
    logic [YW-1:0]       py_nx;
    logic [STEP_W-1:0]   steps_nx;
    logic                win_nx;
    logic                bump_nx;
    logic                armed, armed_nx;

    logic                mv_valid;
    logic                mv_blocked;
    logic [XW-1:0]       mv_nx;
    logic [YW-1:0]       mv_ny;
    logic                take;

    maze_move_check #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_move_check (
        .px       (px),
        .py       (py),
        .dir      (dir),
        .map_bits (map_bits),
        .valid    (mv_valid),
        .blocked  (mv_blocked),
        .nx       (mv_nx),
        .ny       (mv_ny)
    );

    // In press mode a held direction is evaluated once; an idle tick re-arms it.
    assign take = tick && mv_valid && ((EDGE_MODE == 0) || armed);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            px    <= XW'(START_X);
            py    <= YW'(START_Y);
            steps <= '0;
            win   <= 1'b0;
            bump  <= 1'b0;
            armed <= 1'b1;
        end else begin
            state <= state_nx;
            px    <= px_nx;
            py    <= py_nx;
            steps <= steps_nx;
            win   <= win_nx;
            bump  <= bump_nx;
            armed <= armed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        px_nx    = px;
        py_nx    = py;
        steps_nx = steps;
        win_nx   = win;
        bump_nx  = 1'b0;
        armed_nx = armed;

        if (restart) begin
            state_nx = IDLE;
            px_nx    = XW'(START_X);
            py_nx    = YW'(START_Y);
            steps_nx = '0;
            win_nx   = 1'b0;
            armed_nx = 1'b1;
        end else begin
            case (state)
                IDLE, MOVE: begin
                    if (take) begin
                        if (mv_blocked) begin
                            bump_nx = 1'b1;
                        end else begin
                            px_nx    = mv_nx;
                            py_nx    = mv_ny;
                            steps_nx = (steps == '1) ? steps : steps + 1'b1;
                        end
                        armed_nx = 1'b0;
                        state_nx = CHECK;
                    end else if (tick && !mv_valid) begin
                        armed_nx = 1'b1;
                    end
                end
                CHECK: begin
                    if (px == XW'(EXIT_X) && py == YW'(EXIT_Y)) begin
                        state_nx = WIN;
                        win_nx   = 1'b1;
                    end else begin
                        state_nx = MOVE;
                    end
                end
                WIN: begin
                    state_nx = WIN;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench: three walker configurations share one stimulus stream and are
// compared against a cell-grid reference model plus directed scenario expectations.
module tb_maze_walker;

    localparam int W  = 20;
    localparam int H  = 15;
    localparam int SX = 0;
    localparam int SY = 0;
    localparam int EX = 19;
    localparam int EY = 7;

    logic           clk = 1'b0;
    logic           rstn;
    logic           tick;
    logic           restart;
    logic [3:0]     dir;
    logic [W*H-1:0] map;

    logic [4:0]  px0, px1, px2;
    logic [3:0]  py0, py1, py2;
    logic [15:0] s0, s1;
    logic [1:0]  s2;
    logic        win0, win1, win2;
    logic        bump0, bump1, bump2;

    int n_checks = 0;
    int n_fail   = 0;

    int m_x[3];
    int m_y[3];
    int m_steps[3];
    bit m_win[3];
    bit m_bump[3];
    bit m_armed[3];
    bit m_chk[3];
    int cfg_press[3] = '{0, 1, 0};
    int cfg_max[3]   = '{65535, 65535, 3};

    always #5 clk = ~clk;

    maze_walker dut0 (
        .clk(clk), .rstn(rstn), .tick(tick), .dir(dir), .restart(restart), .map_bits(map),
        .px(px0), .py(py0), .win(win0), .bump(bump0), .steps(s0)
    );

    maze_walker #(.EDGE_MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .tick(tick), .dir(dir), .restart(restart), .map_bits(map),
        .px(px1), .py(py1), .win(win1), .bump(bump1), .steps(s1)
    );

    maze_walker #(.STEP_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .tick(tick), .dir(dir), .restart(restart), .map_bits(map),
        .px(px2), .py(py2), .win(win2), .bump(bump2), .steps(s2)
    );

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = SX; m_y[k] = SY; m_steps[k] = 0;
            m_win[k] = 0; m_bump[k] = 0; m_armed[k] = 1; m_chk[k] = 0;
        end
    endfunction

    // One clock edge of game rules: a tick moves one cell, then one settling cycle checks the exit.
    function automatic void model_edge(bit t, logic [3:0] d, bit r);
        int tx, ty;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_x[k] = SX; m_y[k] = SY; m_steps[k] = 0;
                m_win[k] = 0; m_bump[k] = 0; m_armed[k] = 1; m_chk[k] = 0;
            end else begin
                m_bump[k] = 0;
                if (m_win[k]) begin
                end else if (m_chk[k]) begin
                    m_chk[k] = 0;
                    if (m_x[k] == EX && m_y[k] == EY) m_win[k] = 1;
                end else if (t) begin
                    if ($countones(d) == 1) begin
                        if (cfg_press[k] == 0 || m_armed[k]) begin
                            tx = m_x[k] + int'(d == 4'b0010) - int'(d == 4'b1000);
                            ty = m_y[k] + int'(d == 4'b0001) - int'(d == 4'b0100);
                            if (tx >= 0 && tx < W && ty >= 0 && ty < H && map[ty*W+tx] == 1'b0) begin
                                m_x[k] = tx; m_y[k] = ty;
                                if (m_steps[k] < cfg_max[k]) m_steps[k]++;
                            end else begin
                                m_bump[k] = 1;
                            end
                            m_armed[k] = 0;
                            m_chk[k]   = 1;
                        end
                    end else begin
                        m_armed[k] = 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [26:0] obs(int k);
        case (k)
            0:       return {px0, py0, s0, win0, bump0};
            1:       return {px1, py1, s1, win1, bump1};
            default: return {px2, py2, 14'b0, s2, win2, bump2};
        endcase
    endfunction

    function automatic logic [26:0] expv(int k);
        return {5'(m_x[k]), 4'(m_y[k]), 16'(m_steps[k]), m_win[k], m_bump[k]};
    endfunction

    task automatic step(bit t, logic [3:0] d, bit r);
        tick = t; dir = d; restart = r;
        @(posedge clk);
        model_edge(t, d, r);
        @(negedge clk);
        tick = 1'b0; dir = 4'b0000; restart = 1'b0;
    endtask

    // One move that every configuration accepts: tick, settle, idle tick to re-arm.
    task automatic move(logic [3:0] d);
        step(1, d, 0);
        step(0, 4'b0000, 0);
        step(1, 4'b0000, 0);
    endtask

    task automatic walk_to_18_7();
        for (int i = 0; i < 7; i++)  move(4'b0001);
        for (int i = 0; i < 18; i++) move(4'b0010);
    endtask

    task automatic test_reset();
        rstn = 1'b0; tick = 1'b0; restart = 1'b0; dir = 4'b0000; map = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (px0 !== 5'd0 || py0 !== 4'd0 || s0 !== 16'd0 || win0 !== 1'b0 || bump0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: px=%0d py=%0d steps=%0d win=%b bump=%b, want all 0", px0, py0, s0, win0, bump0);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL reset_model dut%0d: got %h want %h", k, obs(k), expv(k));
            end
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_move();
        map = '0;
        step(0, 4'b0000, 1);
        step(1, 4'b0001, 0);
        n_checks++;
        if (px0 !== 5'd0 || py0 !== 4'd1 || s0 !== 16'd1 || bump0 !== 1'b0 || win0 !== 1'b0) begin
            n_fail++;
            $display("FAIL move_down: px=%0d py=%0d steps=%0d bump=%b, want 0 1 1 0", px0, py0, s0, bump0);
        end
        step(0, 4'b0000, 0);
        step(1, 4'b0001, 0);
        n_checks++;
        if (py0 !== 4'd2 || s0 !== 16'd2) begin
            n_fail++;
            $display("FAIL move_after_check: py=%0d steps=%0d, want 2 2", py0, s0);
        end
        step(0, 4'b0000, 0);
    endtask

    task automatic test_wall();
        map = '0;
        step(0, 4'b0000, 1);
        map[1] = 1'b1;
        step(1, 4'b0010, 0);
        n_checks++;
        if (px0 !== 5'd0 || bump0 !== 1'b1 || s0 !== 16'd0) begin
            n_fail++;
            $display("FAIL wall_block: px=%0d bump=%b steps=%0d, want 0 1 0", px0, bump0, s0);
        end
        step(0, 4'b0000, 0);
        n_checks++;
        if (bump0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bump_pulse: bump=%b, want 0", bump0);
        end
        step(1, 4'b1000, 0);
        n_checks++;
        if (px0 !== 5'd0 || bump0 !== 1'b1 || s0 !== 16'd0) begin
            n_fail++;
            $display("FAIL edge_block: px=%0d bump=%b steps=%0d, want 0 1 0", px0, bump0, s0);
        end
        step(0, 4'b0000, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL wall_model dut%0d: got %h want %h", k, obs(k), expv(k));
            end
        end
        map = '0;
    endtask

    task automatic test_win();
        map = '0;
        step(0, 4'b0000, 1);
        walk_to_18_7();
        step(1, 4'b0010, 0);
        n_checks++;
        if (px0 !== 5'd19 || py0 !== 4'd7 || win0 !== 1'b0) begin
            n_fail++;
            $display("FAIL win_e0: px=%0d py=%0d win=%b, want 19 7 0", px0, py0, win0);
        end
        step(0, 4'b0000, 0);
        n_checks++;
        if (win0 !== 1'b1) begin
            n_fail++;
            $display("FAIL win_e1: win=%b, want 1", win0);
        end
        step(1, 4'b1000, 0);
        step(0, 4'b0000, 0);
        n_checks++;
        if (px0 !== 5'd19 || py0 !== 4'd7 || win0 !== 1'b1 || s0 !== 16'd26) begin
            n_fail++;
            $display("FAIL win_frozen: px=%0d py=%0d win=%b steps=%0d, want 19 7 1 26", px0, py0, win0, s0);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL win_model dut%0d: got %h want %h", k, obs(k), expv(k));
            end
        end
        step(0, 4'b0000, 1);
        n_checks++;
        if (px0 !== 5'd0 || py0 !== 4'd0 || win0 !== 1'b0 || s0 !== 16'd0) begin
            n_fail++;
            $display("FAIL win_restart: px=%0d py=%0d win=%b steps=%0d, want 0 0 0 0", px0, py0, win0, s0);
        end
    endtask

    task automatic test_edge_mode();
        map = '0;
        step(0, 4'b0000, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0001, 0);
            step(0, 4'b0000, 0);
        end
        n_checks++;
        if (s1 !== 16'd1 || py1 !== 4'd1 || s0 !== 16'd3) begin
            n_fail++;
            $display("FAIL press_hold: press steps=%0d py=%0d repeat steps=%0d, want 1 1 3", s1, py1, s0);
        end
        step(1, 4'b0000, 0);
        step(1, 4'b0001, 0);
        step(0, 4'b0000, 0);
        n_checks++;
        if (s1 !== 16'd2 || py1 !== 4'd2) begin
            n_fail++;
            $display("FAIL press_rearm: steps=%0d py=%0d, want 2 2", s1, py1);
        end
    endtask

    task automatic test_saturate();
        map = '0;
        step(0, 4'b0000, 1);
        for (int i = 0; i < 5; i++) move(4'b0001);
        n_checks++;
        if (s2 !== 2'd3 || s0 !== 16'd5 || py2 !== 4'd5) begin
            n_fail++;
            $display("FAIL steps_saturate: narrow=%0d wide=%0d py=%0d, want 3 5 5", s2, s0, py2);
        end
    endtask

    task automatic test_restart_tick();
        step(1, 4'b0001, 1);
        n_checks++;
        if (px0 !== 5'd0 || py0 !== 4'd0 || s0 !== 16'd0 || bump0 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_priority: px=%0d py=%0d steps=%0d bump=%b, want 0 0 0 0", px0, py0, s0, bump0);
        end
        step(0, 4'b0000, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL restart_model dut%0d: got %h want %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_async_reset();
        map = '0;
        step(0, 4'b0000, 1);
        walk_to_18_7();
        step(1, 4'b0010, 0);
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (px0 !== 5'd0 || py0 !== 4'd0 || s0 !== 16'd0 || win0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: px=%0d py=%0d steps=%0d win=%b, want 0 0 0 0", px0, py0, s0, win0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (win0 !== 1'b0 || px0 !== 5'd0) begin
            n_fail++;
            $display("FAIL async_hold: win=%b px=%0d, want 0 0", win0, px0);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(0, 4'b0000, 0);
        step(0, 4'b0000, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL async_model dut%0d: got %h want %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        int sel;
        map = '0;
        step(0, 4'b0000, 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                for (int b = 0; b < W*H; b++) map[b] = ($urandom_range(0, 5) == 0);
                map[0] = 1'b0;
            end
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: d = 4'b0010;
                3, 4, 5: d = 4'b0001;
                6:       d = 4'b1000;
                7:       d = 4'b0100;
                8:       d = 4'($urandom_range(0, 15));
                default: d = 4'b0000;
            endcase
            step($urandom_range(0, 2) != 0, d, $urandom_range(0, 299) == 0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cycle %0d: got %h want %h", k, i, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_wall();
        test_win();
        test_edge_mode();
        test_saturate();
        test_restart_tick();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
# maze_walker

Parametrised player-position engine for the VGA maze game. It owns the player's grid coordinates and steps them one cell per move tick in the commanded direction, checking walls and grid edges against a supplied occupancy bitmap. It detects arrival at the exit cell and counts steps. It sits between the debounced switch/PS2 direction source and the VGA renderer, which reads `px`/`py`/`win`.

## Interface
Parameters:
- `MAP_W`, 20, grid width in cells
- `MAP_H`, 15, grid height in cells
- `START_X`, 0, start column
- `START_Y`, 0, start row
- `EXIT_X`, 19, exit column
- `EXIT_Y`, 7, exit row
- `STEP_W`, 16, step counter width
- `EDGE_MODE`, 0, 0 = hold-to-repeat (one step per tick while held); 1 = one step per press
- Derived: `XW = $clog2(MAP_W)`, `YW = $clog2(MAP_H)`

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous, active-low reset
- `tick`  in  1  move-rate strobe, one `clk` wide (e.g. 100 ms)
- `dir`  in  4  direction command: 4'b1000 left, 4'b0100 up, 4'b0010 right, 4'b0001 down; anything else = no command
- `restart`  in  1  synchronous new-game request
- `map_bits`  in  MAP_W*MAP_H  wall bitmap, bit index `y*MAP_W+x`, 1 = wall
- `px`  out  XW  player column
- `py`  out  YW  player row
- `win`  out  1  level complete, held high
- `bump`  out  1  one-`clk` pulse when a commanded move is refused
- `steps`  out  STEP_W  successful moves since start, saturating

## Operation
- FSM states: IDLE, MOVE, CHECK, WIN.
- IDLE: player sits at START. The first `tick` with a valid one-hot `dir` is evaluated as a move, and the FSM enters CHECK. A tick with an invalid `dir` is ignored.
- MOVE: each `tick` with a valid `dir` is evaluated, and the FSM enters CHECK. A tick with no valid command stays in MOVE.
- Move evaluation happens in the tick cycle, using the `map_bits` value sampled on that edge.
  - A move is blocked if the target leaves the grid (x<0, x>MAP_W-1, y<0, y>MAP_H-1) or the target bit is 1.
  - The edge check precedes the bitmap index, so out-of-range indices are never read.
  - Allowed move: update `px`/`py`; `steps` +1, saturating at all-ones.
  - Blocked move: position unchanged, `bump`=1 for that cycle, `steps` unchanged.
- CHECK (exactly one `clk`):
  - If `px==EXIT_X && py==EXIT_Y`, go to WIN.
  - Otherwise go to MOVE.
  - A `tick` arriving in CHECK is dropped.
- WIN: `win`=1; position and `steps` frozen; ticks ignored until `restart`.
- EDGE_MODE=1:
  - An `armed` flag clears on every evaluated move, allowed or blocked.
  - It re-arms when `dir` is not one-hot on a `tick`.
  - Ticks with `armed`=0 are ignored.
  - Reset and restart set `armed`=1.
- `restart`, from any state: `px`=START_X, `py`=START_Y, `steps`=0, `win`=0, `bump`=0, `armed`=1, next state IDLE.
- `restart` has priority over a simultaneous `tick`.
- If START equals EXIT, the first allowed move away still counts. Win is tested only in CHECK, never in IDLE.

## Timing
- Reset values: `px`=START_X, `py`=START_Y, `win`=0, `bump`=0, `steps`=0, state IDLE, `armed`=1.
- Let E0 be the edge sampling `tick`=1.
  - `px`/`py`/`steps`/`bump` change after E0.
  - CHECK occupies E0→E1.
  - `win` rises after E1, i.e. 2 edges after the tick.
- `bump` is registered and falls after E1.
- `restart` takes effect on the next edge; outputs show start values one cycle later.
- Reset mid-move (`rstn` low, any phase) forces reset values immediately, independent of `clk`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `maze_pkg` holds:
  - direction codes DIR_LEFT/UP/RIGHT/DOWN/NONE
  - FSM state enum
- Sub-module `maze_move_check` (combinational) takes `px`, `py`, `dir`, `map_bits`. It returns `valid`, `blocked`, `nx`, `ny`, and contains all edge and wall logic.

## Test plan
- Reset with defaults and an all-zero map: `px`=0, `py`=0, `steps`=0, `win`=0. Tick with `dir`=0001 gives `py`=1, `steps`=1, state passes CHECK→MOVE.
- Wall: set bit 1 (x=1,y=0); tick with `dir`=0010 from (0,0) gives `px`=0, one `bump` pulse, `steps`=0. Tick with `dir`=1000 gives `bump` (grid edge), no index fault.
- Win: place the player at (18,7) via direct moves; tick right gives `px`=19 after E0 and `win`=1 after E1. Further ticks leave position 19,7; `restart` returns to (0,0), `win`=0.
- EDGE_MODE=1: hold `dir`=0001 for 3 ticks gives exactly 1 step. A tick with `dir`=0000, then `dir`=0001, gives a second step.
- STEP_W=2: 5 allowed moves gives `steps`=3, saturated.
- Simultaneous `restart`+`tick` with a valid dir gives start position, `steps`=0, no move. Assert `rstn`=0 during CHECK: outputs reset asynchronously, `win` never rises.
